scan_dec: RTL and testbench
===========================

SCAN_DEC -- requirements
Module: scan_dec

Interface
REQ-001 Parameter IN_W, default 3: index width; output width is 2**IN_W, legal range 1..6.
REQ-002 Parameter DIV_W, default 16: width of the scan-period divider.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 en  input  1  global enable; 0 forces out to all-zero.
REQ-006 mode  input  1  0 = direct decode, 1 = auto-scan.
REQ-007 sel  input  IN_W  direct-mode index.
REQ-008 div  input  DIV_W  scan dwell minus 1, in clk cycles.
REQ-009 out  output  2**IN_W  registered one-hot select.
REQ-010 idx  output  IN_W  registered active index; always consistent with out when out is non-zero.
REQ-011 wrap  output  1  one-cycle pulse when the scan index wraps to 0.

Function
REQ-012 The block SHALL implement states IDLE (en=0), DIRECT (en=1, mode=0) and SCAN (en=1, mode=1), re-evaluated every cycle from en and mode.
REQ-013 IDLE: out<=0, wrap<=0, idx and divider count cnt held.
REQ-014 DIRECT: idx<=sel, out<=onehot(sel), cnt<=0, wrap<=0; latency 1 cycle from sel to out.
REQ-015 SCAN: cnt increments each cycle; when cnt>=div, cnt<=0 and idx advances to the next index.
REQ-016 SCAN with div=0 SHALL advance idx every cycle.
REQ-017 Index advance from 2**IN_W-1 SHALL wrap to 0 and assert wrap for exactly that cycle.
REQ-018 On entry to SCAN from DIRECT or IDLE, cnt SHALL start at 0 and the scan SHALL resume from the held idx; out<=onehot(idx) in the first SCAN cycle.
REQ-019 div reduced below the current cnt SHALL cause advance on the next cycle (>= comparison, no counter overrun).
REQ-020 out SHALL never have more than one bit set.

Reset
REQ-021 While rst=1: out=0, idx=0, cnt=0, wrap=0, state IDLE; asserting rst mid-dwell SHALL abandon the dwell with no wrap pulse.
REQ-022 The first cycle after rst deasserts SHALL behave as REQ-012..020 from the reset values.

Configuration
REQ-023 Macro SCAN_DEC_MASK_EN, when defined, SHALL add input mask (2**IN_W bits, 1 = channel enabled).
REQ-024 With SCAN_DEC_MASK_EN, SCAN SHALL advance idx to the next enabled index in ascending order, and wrap SHALL pulse when the search passes index 2**IN_W-1.
REQ-025 With SCAN_DEC_MASK_EN, mask all-zero SHALL force out=0 and wrap=0 in SCAN; DIRECT ignores mask.
REQ-026 Without SCAN_DEC_MASK_EN, no mask port SHALL exist and all channels SHALL be scanned.

Structure
REQ-027 State encoding and the onehot function SHALL live in the shared package scan_dec_pkg.
REQ-028 The divider SHALL be a sub-module scan_div (cnt, div compare, tick output).

Verification
REQ-029 IN_W=2, en=1, mode=0, sel=2 -> out=4'b0100, idx=2 one cycle later.
REQ-030 IN_W=2, mode=1, div=2 -> idx sequence 0,1,2,3,0 with 3-cycle dwell; wrap high for 1 cycle when idx returns to 0.
REQ-031 SCAN with div=0 -> out rotates 0001,0010,0100,1000 on consecutive cycles.
REQ-032 en dropped for 5 cycles mid-dwell -> out=0; on re-enable, scan resumes at the same idx with cnt=0.
REQ-033 rst pulse mid-scan at idx=3 -> out=0, idx=0 asynchronously, no wrap pulse.
REQ-034 SCAN_DEC_MASK_EN, mask=4'b1010, div=0 -> idx alternates 1,3,1,3 with wrap on each 3->1 transition.

Source files
------------

// File: rtl/scan_dec_pkg.sv
// Shared definitions for the scan decoder: operating states and the one-hot
// helper used by the top and the bench.
package scan_dec_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIRECT = 2'd1,
        ST_SCAN   = 2'd2
    } state_e;

    // Widest supported index; callers cast the result down to 2**IN_W bits.
    localparam int MAX_IN_W  = 6;
    localparam int MAX_OUT_W = 2 ** MAX_IN_W;

    function automatic logic [MAX_OUT_W-1:0] onehot(input logic [MAX_IN_W-1:0] i);
        onehot    = '0;
        onehot[i] = 1'b1;
    endfunction

    function automatic state_e decode_state(input logic en, input logic mode);
        if (!en)
            return ST_IDLE;
        return mode ? ST_SCAN : ST_DIRECT;
    endfunction

endpackage

// File: rtl/scan_div.sv
// Scan dwell divider: counts cycles while running and flags when the count
// has reached the programmed dwell (cnt >= div), restarting from zero.
module scan_div #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             run_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             tick_o,
    output logic [DIV_W-1:0] cnt_o
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    // Greater-or-equal so a div lowered below cnt expires on the next run cycle.
    assign tick_o = (cnt_q >= div_i);
    assign cnt_o  = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (run_i)
            cnt_d = tick_o ? '0 : cnt_q + DIV_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/scan_dec.sv
// Registered one-hot decoder with direct select and timed auto-scan.
// Optional macro SCAN_DEC_MASK_EN adds a per-channel scan mask input.
module scan_dec
    import scan_dec_pkg::*;
#(
    parameter int IN_W  = 3,   // legal range 1..6
    parameter int DIV_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                mode,
    input  logic [IN_W-1:0]     sel,
    input  logic [DIV_W-1:0]    div,
`ifdef SCAN_DEC_MASK_EN
    input  logic [2**IN_W-1:0]  mask,
`endif
    output logic [2**IN_W-1:0]  out,
    output logic [IN_W-1:0]     idx,
    output logic                wrap,
    output state_e              dbg_state_o,
    output logic [DIV_W-1:0]    dbg_cnt_o
);

    localparam int N = 2 ** IN_W;

    state_e          state_q;
    state_e          state_d;
    logic [IN_W-1:0] idx_q;
    logic [IN_W-1:0] idx_d;
    logic [N-1:0]    out_q;
    logic [N-1:0]    out_d;
    logic            wrap_q;
    logic            wrap_d;

    logic            div_clr;
    logic            div_run;
    logic            div_tick;
    logic [N-1:0]    ch_en;
    logic [IN_W-1:0] nxt_idx;
    logic            nxt_wrap;
    logic            found;
    logic [IN_W-1:0] cand;

`ifdef SCAN_DEC_MASK_EN
    assign ch_en = mask;
`else
    assign ch_en = '1;
`endif

    scan_div #(
        .DIV_W (DIV_W)
    ) u_div (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (div_clr),
        .run_i  (div_run),
        .div_i  (div),
        .tick_o (div_tick),
        .cnt_o  (dbg_cnt_o)
    );

    // Next enabled channel above idx_q, searching circularly; k == N lands back
    // on idx_q itself, which covers a single enabled channel.
    always_comb begin
        nxt_idx  = idx_q;
        nxt_wrap = 1'b0;
        found    = 1'b0;
        cand     = idx_q;
        for (int k = 1; k <= N; k++) begin
            cand = idx_q + IN_W'(k);
            if (!found && ch_en[cand]) begin
                found    = 1'b1;
                nxt_idx  = cand;
                nxt_wrap = (int'(idx_q) + k) >= N;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = decode_state(en, mode);
    end

    always_comb begin
        idx_d   = idx_q;
        out_d   = '0;
        wrap_d  = 1'b0;
        div_clr = 1'b0;
        div_run = 1'b0;
        unique case (state_d)
            ST_IDLE: begin
                // hold idx and divider count, blank the output
            end
            ST_DIRECT: begin
                idx_d   = sel;
                out_d   = N'(onehot(MAX_IN_W'(sel)));
                div_clr = 1'b1;
            end
            ST_SCAN: begin
                // First scan cycle restarts the dwell and shows the held index.
                if (state_q != ST_SCAN) begin
                    div_clr = 1'b1;
                end else begin
                    div_run = 1'b1;
                    if (div_tick) begin
                        idx_d  = nxt_idx;
                        wrap_d = nxt_wrap;
                    end
                end
                out_d = N'(onehot(MAX_IN_W'(idx_d))) & ch_en;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q  <= '0;
            out_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            out_q  <= out_d;
            wrap_q <= wrap_d;
        end
    end

    assign out         = out_q;
    assign idx         = idx_q;
    assign wrap        = wrap_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_scan_dec.sv
// Self-checking bench for scan_dec: directed table, corner sequences and
// randomized traffic against a behavioural model. Define SCAN_DEC_MASK_EN to cover the mask.
module tb_scan_dec;
    import scan_dec_pkg::*;

    localparam int IN_W  = 2;
    localparam int DIV_W = 4;
    localparam int N     = 2 ** IN_W;
    localparam int W     = N + IN_W + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en = 1'b0;
    logic             mode = 1'b0;
    logic [IN_W-1:0]  sel = '0;
    logic [DIV_W-1:0] div = '0;
    logic [N-1:0]     mask_v = '1;
    logic [N-1:0]     out;
    logic [IN_W-1:0]  idx;
    logic             wrap;
    state_e           dbg_state;
    logic [DIV_W-1:0] dbg_cnt;

    int n_total = 0;
    int n_bad   = 0;
    logic [W-1:0] exp_q[$];

    // behavioural model state
    int           m_idx;
    int           m_cnt;
    bit           m_in_scan;
    logic [N-1:0] m_out;
    bit           m_wrap;

    typedef struct {
        logic         en;
        logic         mode;
        int           sel;
        int           div;
        logic [N-1:0] out;
        int           idx;
        logic         wrap;
    } vec_t;
    vec_t tbl[19];

    scan_dec #(
        .IN_W  (IN_W),
        .DIV_W (DIV_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .mode        (mode),
        .sel         (sel),
        .div         (div),
`ifdef SCAN_DEC_MASK_EN
        .mask        (mask_v),
`endif
        .out         (out),
        .idx         (idx),
        .wrap        (wrap),
        .dbg_state_o (dbg_state),
        .dbg_cnt_o   (dbg_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_idx     = 0;
        m_cnt     = 0;
        m_in_scan = 0;
        m_out     = '0;
        m_wrap    = 0;
        exp_q.delete();
    endtask

    // One clock edge of the model with the inputs currently driven.
    task automatic model_edge();
        m_wrap = 0;
        if (!en) begin
            m_out     = '0;
            m_in_scan = 0;
        end else if (!mode) begin
            m_idx     = int'(sel);
            m_cnt     = 0;
            m_out     = N'(1) << m_idx;
            m_in_scan = 0;
        end else begin
            if (!m_in_scan) begin
                m_cnt = 0;
            end else if (m_cnt >= int'(div)) begin
                m_cnt = 0;
                for (int k = 1; k <= N; k++) begin
                    if (mask_v[(m_idx + k) % N]) begin
                        m_wrap = (m_idx + k) >= N;
                        m_idx  = (m_idx + k) % N;
                        break;
                    end
                end
            end else begin
                m_cnt++;
            end
            m_in_scan = 1;
            m_out = mask_v[m_idx] ? (N'(1) << m_idx) : '0;
        end
        exp_q.push_back({m_out, IN_W'(m_idx), m_wrap});
    endtask

    task automatic sb_check();
        logic [W-1:0] e;
        if (exp_q.size() == 0) begin
            n_total++;
            n_bad++;
            $display("FAIL scoreboard: expected queue empty");
            return;
        end
        e = exp_q.pop_front();
        check("model", 32'({out, idx, wrap}), 32'(e));
        check("onehot", 32'($countones(out) <= 1), 32'(1));
    endtask

    task automatic step(input logic e, input logic m, input int s, input int d);
        @(negedge clk);
        en   = e;
        mode = m;
        sel  = IN_W'(s);
        div  = DIV_W'(d);
        model_edge();
        @(posedge clk);
        #1;
        sb_check();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst  = 1'b1;
        en   = 1'b0;
        mode = 1'b0;
        sel  = '0;
        div  = '0;
        model_reset();
        #1;
        check("rst_out", 32'(out), 32'(0));
        check("rst_idx", 32'(idx), 32'(0));
        check("rst_wrap", 32'(wrap), 32'(0));
        check("rst_cnt", 32'(dbg_cnt), 32'(0));
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 2, 0, 4'b0100, 2, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1, 0, 4'b0010, 1, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 0, 2, 4'b0010, 1, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 0, 2, 4'b0010, 1, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 0, 2, 4'b0010, 1, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 0, 2, 4'b0100, 2, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 0, 2, 4'b0100, 2, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 0, 2, 4'b0100, 2, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 0, 2, 4'b1000, 3, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, 0, 2, 4'b1000, 3, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 0, 2, 4'b1000, 3, 1'b0};
        tbl[11] = '{1'b1, 1'b1, 0, 2, 4'b0001, 0, 1'b1};
        tbl[12] = '{1'b1, 1'b1, 0, 2, 4'b0001, 0, 1'b0};
        tbl[13] = '{1'b0, 1'b1, 0, 2, 4'b0000, 0, 1'b0};
        tbl[14] = '{1'b1, 1'b0, 3, 0, 4'b1000, 3, 1'b0};
        tbl[15] = '{1'b1, 1'b1, 0, 0, 4'b1000, 3, 1'b0};
        tbl[16] = '{1'b1, 1'b1, 0, 0, 4'b0001, 0, 1'b1};
        tbl[17] = '{1'b1, 1'b1, 0, 0, 4'b0010, 1, 1'b0};
        tbl[18] = '{1'b1, 1'b1, 0, 0, 4'b0100, 2, 1'b0};

        // directed table
        do_reset();
        for (int i = 0; i < 19; i++) begin
            step(tbl[i].en, tbl[i].mode, tbl[i].sel, tbl[i].div);
            check($sformatf("tbl%0d_out", i), 32'(out), 32'(tbl[i].out));
            check($sformatf("tbl%0d_idx", i), 32'(idx), 32'(tbl[i].idx));
            check($sformatf("tbl%0d_wrap", i), 32'(wrap), 32'(tbl[i].wrap));
        end

        // three-cycle dwell from reset, wrap on return to 0
        do_reset();
        for (int t = 0; t < 15; t++) begin
            step(1'b1, 1'b1, 0, 2);
            check($sformatf("dwell%0d_idx", t), 32'(idx), 32'((t / 3) % 4));
            check($sformatf("dwell%0d_wrap", t), 32'(wrap),
                  32'(t > 0 && t % 3 == 0 && (t / 3) % 4 == 0));
        end

        // enable dropped mid-dwell, then resume with a fresh dwell
        do_reset();
        for (int t = 0; t < 6; t++) step(1'b1, 1'b1, 0, 3);
        check("pause_pre_idx", 32'(idx), 32'(1));
        for (int t = 0; t < 5; t++) begin
            step(1'b0, 1'b1, 0, 3);
            check("pause_out", 32'(out), 32'(0));
            check("pause_idx", 32'(idx), 32'(1));
        end
        step(1'b1, 1'b1, 0, 3);
        check("resume_idx", 32'(idx), 32'(1));
        check("resume_out", 32'(out), 32'(4'b0010));
        check("resume_cnt", 32'(dbg_cnt), 32'(0));
        for (int t = 0; t < 3; t++) step(1'b1, 1'b1, 0, 3);
        check("resume_hold_idx", 32'(idx), 32'(1));
        step(1'b1, 1'b1, 0, 3);
        check("resume_adv_idx", 32'(idx), 32'(2));

        // div lowered below the running count forces an advance next cycle
        do_reset();
        for (int t = 0; t < 4; t++) step(1'b1, 1'b1, 0, 5);
        check("shrink_cnt", 32'(dbg_cnt), 32'(3));
        check("shrink_pre_idx", 32'(idx), 32'(0));
        step(1'b1, 1'b1, 0, 1);
        check("shrink_idx", 32'(idx), 32'(1));
        check("shrink_cnt0", 32'(dbg_cnt), 32'(0));

        // asynchronous reset mid-scan at idx 3
        do_reset();
        step(1'b1, 1'b0, 3, 0);
        step(1'b1, 1'b1, 0, 5);
        step(1'b1, 1'b1, 0, 5);
        check("arst_pre_idx", 32'(idx), 32'(3));
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check("arst_out", 32'(out), 32'(0));
        check("arst_idx", 32'(idx), 32'(0));
        check("arst_wrap", 32'(wrap), 32'(0));
        @(posedge clk);
        #1;
        check("arst_hold_wrap", 32'(wrap), 32'(0));
        check("arst_hold_out", 32'(out), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 1'b1, 0, 5);
        check("arst_after_idx", 32'(idx), 32'(0));
        check("arst_after_out", 32'(out), 32'(4'b0001));

`ifdef SCAN_DEC_MASK_EN
        // masked scan alternates between the two enabled channels
        do_reset();
        mask_v = 4'b1010;
        step(1'b1, 1'b1, 0, 0);
        check("mask_entry_out", 32'(out), 32'(0));
        for (int t = 1; t < 7; t++) begin
            step(1'b1, 1'b1, 0, 0);
            check($sformatf("mask%0d_idx", t), 32'(idx), 32'((t % 2 == 1) ? 1 : 3));
            check($sformatf("mask%0d_wrap", t), 32'(wrap), 32'(t % 2 == 1 && t > 1));
        end
        mask_v = 4'b0000;
        step(1'b1, 1'b1, 0, 0);
        check("mask_none_out", 32'(out), 32'(0));
        step(1'b1, 1'b0, 2, 0);
        check("mask_direct_out", 32'(out), 32'(4'b0100));
        mask_v = '1;
`endif

        // randomized traffic against the model
        do_reset();
        for (int t = 0; t < 600; t++) begin
`ifdef SCAN_DEC_MASK_EN
            if ($urandom_range(0, 15) == 0) mask_v = N'($urandom);
`endif
            step(($urandom_range(0, 9) != 0), ($urandom_range(0, 3) != 0),
                 int'($urandom_range(0, N - 1)), int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
